mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle MULT/DIV datapath unit sitting downstream of the control unit; consumes
//  its start strobes and the A/B register values, produces HI/LO results.
//  Radix-2 Booth multiply and restoring divide, one iteration per clock.
//  The control unit waits on busy/done before writing HI/LO via the existing HI/LO muxes.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high; clears all state
//  mult_start  in   1      start signed multiply, sampled only in IDLE
//  div_start   in   1      start signed divide, sampled only in IDLE
//  a_in        in   WIDTH  operand A (multiplicand / dividend), latched at start
//  b_in        in   WIDTH  operand B (multiplier / divisor), latched at start
//  hi_out      out  WIDTH  MULT: upper product half; DIV: remainder
//  lo_out      out  WIDTH  MULT: lower product half; DIV: quotient
//  busy        out  1      high from cycle after accepted start until DONE exits
//  done        out  1      single-cycle pulse, results valid on hi_out/lo_out
//  div_zero    out  1      high with done when divisor was 0; held until next start
// BEHAVIOUR
//  Reset: state=IDLE; hi_out, lo_out, busy, done, div_zero, internal regs = 0.
//  FSM: IDLE -> MULT | DIV -> DONE -> IDLE.
//   IDLE: mult_start=1 -> MULT (latch a_in/b_in, count=0); else div_start=1 -> DIV.
//         Both strobes high same cycle: MULT wins, div_start dropped.
//   MULT: Booth step per cycle on {acc, multiplier, q-1}, arithmetic shift right;
//         after WIDTH steps -> DONE, hi_out/lo_out loaded on that edge.
//   DIV:  divisor==0 at latch -> DONE next cycle, div_zero=1, hi_out/lo_out unchanged.
//         Otherwise restoring division on |a|,|b| for WIDTH steps, then sign fix:
//         quotient truncates toward zero; remainder takes sign of dividend.
//         -2^(WIDTH-1) / -1: lo_out=0x80000000, hi_out=0 (wrap, no flag).
//   DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
//  Latency: start seen at edge N -> done high in cycle after edge N+WIDTH+1
//   (33 cycles for WIDTH=32); div-by-zero: done after edge N+2.
//  Starts while busy/in DONE are ignored (no queueing).
//  hi_out/lo_out hold last result until next successful completion.
//  div_zero cleared on any accepted start.
//  Reset mid-operation: abort immediately, all outputs 0, no done pulse.
//  a_in/b_in changes after the start edge have no effect.
// CONFIGURATION
//  MULT_DIV_UNSIGNED_EN defined: adds input port op_unsigned (1 bit, sampled with
//   start); op_unsigned=1 performs MULTU/DIVU (zero-extended operands, no sign fix).
//  Not defined: port absent; all operations signed.
// TESTING
//  mult_start, a=7, b=0xFFFFFFFD -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  div_start, a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
//  div_start, a=5, b=0 -> done after 2 cycles, div_zero=1, hi/lo keep prior values.
//  mult_start+div_start same cycle, a=3, b=4 -> multiply: hi=0, lo=12; second start
//   pulse at cycle 10 ignored, single done pulse only.
//  reset asserted at cycle 15 of MULT -> outputs 0, busy=0, no done; new mult accepted.
//  MULT_DIV_UNSIGNED_EN: op_unsigned=1, a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit for HI/LO.
// Define MULT_DIV_UNSIGNED_EN to add op_unsigned for MULTU/DIVU.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
`ifdef MULT_DIV_UNSIGNED_EN
   ,
   input  logic             op_unsigned
`endif
);

   localparam int XW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [XW-1:0]    acc_q, m_q;
   logic [WIDTH-1:0] mq_q, hi_q, lo_q;
   logic             qm1_q, sr_q, sq_q, uns_q, dz_q;
   logic             uns_in;

`ifdef MULT_DIV_UNSIGNED_EN
   assign uns_in = op_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   logic [XW-1:0]    booth_sum, div_sh, div_trial, acc_step;
   logic [WIDTH-1:0] mq_step, hi_mul, q_fix, r_fix;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             a_neg, b_neg, last, first, dzero;

   assign last  = (cnt_q == CW'(WIDTH));
   assign first = (cnt_q == CW'(1));
   assign dzero = (m_q[WIDTH-1:0] == '0);

   // Cycle 0 of an op turns the raw latched operands into working form.
   assign a_neg = ~uns_q & mq_q[WIDTH-1];
   assign b_neg = ~uns_q & m_q[WIDTH-1];
   assign a_mag = a_neg ? -mq_q : mq_q;
   assign b_mag = b_neg ? -m_q[WIDTH-1:0] : m_q[WIDTH-1:0];

   always_comb begin
      case ({mq_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + m_q;
         2'b10:   booth_sum = acc_q - m_q;
         default: booth_sum = acc_q;
      endcase
      div_sh    = {acc_q[XW-2:0], mq_q[WIDTH-1]};
      div_trial = div_sh - m_q;
      if (state_q == S_MULT) begin
         acc_step = {booth_sum[XW-1], booth_sum[XW-1:1]};
         mq_step  = {booth_sum[0], mq_q[WIDTH-1:1]};
      end else begin
         acc_step = div_trial[XW-1] ? div_sh : div_trial;
         mq_step  = {mq_q[WIDTH-2:0], ~div_trial[XW-1]};
      end
   end

   // Unsigned multiplier with MSB set: Booth saw it as negative, add M back.
   assign hi_mul = acc_step[WIDTH-1:0]
                 + (sr_q ? m_q[WIDTH-1:0] : '0);
   assign q_fix  = sq_q ? -mq_step : mq_step;
   assign r_fix  = sr_q ? -acc_step[WIDTH-1:0]
                        : acc_step[WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (mult_start)
               state_d = S_MULT;
            else if (div_start)
               state_d = S_DIV;
         end
         S_MULT, S_DIV: begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_DIV && first && dzero)
               state_d = S_DONE;
            else if (last)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         mq_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qm1_q   <= 1'b0;
         sr_q    <= 1'b0;
         sq_q    <= 1'b0;
         uns_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         case (state_q)
            S_IDLE: begin
               if (mult_start || div_start) begin
                  uns_q <= uns_in;
                  acc_q <= '0;
                  qm1_q <= 1'b0;
                  sr_q  <= 1'b0;
                  sq_q  <= 1'b0;
                  dz_q  <= 1'b0;
                  if (mult_start) begin
                     m_q  <= {2'b00, a_in};
                     mq_q <= b_in;
                  end else begin
                     m_q  <= {2'b00, b_in};
                     mq_q <= a_in;
                  end
               end
            end
            S_MULT, S_DIV: begin
               if (cnt_q == '0) begin
                  if (state_q == S_MULT) begin
                     m_q  <= uns_q
                           ? {2'b00, m_q[WIDTH-1:0]}
                           : {{2{m_q[WIDTH-1]}}, m_q[WIDTH-1:0]};
                     sr_q <= uns_q & mq_q[WIDTH-1];
                  end else begin
                     m_q  <= {2'b00, b_mag};
                     mq_q <= a_mag;
                     sr_q <= a_neg;
                     sq_q <= a_neg ^ b_neg;
                  end
               end else begin
                  acc_q <= acc_step;
                  mq_q  <= mq_step;
                  qm1_q <= mq_q[0];
                  if (state_q == S_DIV && first && dzero)
                     dz_q <= 1'b1;
                  else if (last && state_q == S_MULT) begin
                     hi_q <= hi_mul;
                     lo_q <= mq_step;
                  end else if (last) begin
                     hi_q <= r_fix;
                     lo_q <= q_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign div_zero = dz_q;
   assign done     = (state_q == S_DONE);
   assign busy     = (state_q == S_MULT) || (state_q == S_DIV);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: spec vectors, corner sequences and a
// randomized run against an arithmetic reference model.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        mult_start, div_start;
   logic [31:0] a_in, b_in;
   logic [31:0] hi_out, lo_out;
   logic        busy, done, div_zero;
`ifdef MULT_DIV_UNSIGNED_EN
   logic        op_unsigned;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .a_in       (a_in),
      .b_in       (b_in),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
`ifdef MULT_DIV_UNSIGNED_EN
      ,
      .op_unsigned(op_unsigned)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      bit          dz;
      int          lat;
   } vec_t;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h",
                  name, act, exp);
   endtask

   task automatic run_op(input bit is_div,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input bit uns,
                         output int lat);
      @(negedge clk);
      a_in       = a;
      b_in       = b;
      mult_start = !is_div;
      div_start  = is_div;
`ifdef MULT_DIV_UNSIGNED_EN
      op_unsigned = uns;
`else
      if (uns)
         $display("note: unsigned op requested in signed build");
`endif
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      a_in       = $urandom;
      b_in       = $urandom;
`ifdef MULT_DIV_UNSIGNED_EN
      op_unsigned = ~uns;
`endif
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1)
            check("busy_after_start", {31'b0, busy}, 32'd1);
      end
      if (done !== 1'b1)
         lat = -1;
      else
         check("busy_at_done", {31'b0, busy}, 32'd0);
   endtask

   // Reference: plain 64-bit arithmetic on the architectural operands.
   task automatic model(input bit is_div, input bit uns,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        inout logic [31:0] hi,
                        inout logic [31:0] lo,
                        output bit dz);
      longint sa, sb, p, q, r;
      sa = uns ? longint'({32'b0, a}) : longint'($signed(a));
      sb = uns ? longint'({32'b0, b}) : longint'($signed(b));
      dz = 1'b0;
      if (!is_div) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end
   endtask

   vec_t        vecs[8];
   int          lat, ndone;
   logic [31:0] e_hi, e_lo;
   bit          e_dz, rdiv, runs;
   logic [31:0] ra, rb;

   initial begin
      vecs[0] = '{0, 32'd7, 32'hFFFFFFFD,
                  32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33};
      vecs[1] = '{1, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33};
      vecs[2] = '{1, 32'd5, 32'd0,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 1, 2};
      vecs[3] = '{1, 32'h80000000, 32'hFFFFFFFF,
                  32'h0, 32'h80000000, 0, 33};
      vecs[4] = '{0, 32'h80000000, 32'h80000000,
                  32'h40000000, 32'h0, 0, 33};
      vecs[5] = '{1, 32'd100, 32'hFFFFFFF9,
                  32'd2, 32'hFFFFFFF2, 0, 33};
      vecs[6] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h0, 32'h1, 0, 33};
      vecs[7] = '{1, 32'd7, 32'd9,
                  32'd7, 32'd0, 0, 33};

      reset      = 1'b1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      a_in       = '0;
      b_in       = '0;
`ifdef MULT_DIV_UNSIGNED_EN
      op_unsigned = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_hi", hi_out, 32'd0);
      check("rst_lo", lo_out, 32'd0);
      check("rst_flags", {29'b0, busy, done, div_zero}, 32'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, 1'b0, lat);
         check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
         check($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
         check($sformatf("v%0d_dz", i),
               {31'b0, div_zero}, {31'b0, vecs[i].dz});
      end

      // Both strobes together, plus a stray start while busy.
      @(negedge clk);
      a_in       = 32'd3;
      b_in       = 32'd4;
      mult_start = 1'b1;
      div_start  = 1'b1;
      ndone      = 0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         mult_start = 1'b0;
         if (done === 1'b1)
            ndone++;
         div_start = (k == 10);
         if (k == 10) begin
            a_in = 32'd100;
            b_in = 32'd5;
         end
      end
      check("both_ndone", ndone, 32'd1);
      check("both_hi", hi_out, 32'd0);
      check("both_lo", lo_out, 32'd12);
      check("both_dz", {31'b0, div_zero}, 32'd0);

      // Reset in the middle of a multiply.
      @(negedge clk);
      a_in       = 32'd123;
      b_in       = 32'd456;
      mult_start = 1'b1;
      @(negedge clk);
      mult_start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_hi", hi_out, 32'd0);
      check("midrst_lo", lo_out, 32'd0);
      check("midrst_flags", {29'b0, busy, done, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1)
            ndone++;
      end
      check("midrst_idle", ndone, 32'd0);
      run_op(1'b0, 32'd6, 32'd7, 1'b0, lat);
      check("postrst_lat", lat, 32'd33);
      check("postrst_lo", lo_out, 32'd42);

`ifdef MULT_DIV_UNSIGNED_EN
      run_op(1'b0, 32'hFFFFFFFF, 32'd2, 1'b1, lat);
      check("multu_hi", hi_out, 32'd1);
      check("multu_lo", lo_out, 32'hFFFFFFFE);
      run_op(1'b1, 32'hFFFFFFFF, 32'd2, 1'b1, lat);
      check("divu_lo", lo_out, 32'h7FFFFFFF);
      check("divu_hi", hi_out, 32'd1);
`endif

      e_hi = hi_out === 32'd1 ? 32'd1 : 32'd0;
      e_lo = lo_out === 32'h7FFFFFFF ? 32'h7FFFFFFF : 32'd42;
`ifndef MULT_DIV_UNSIGNED_EN
      e_hi = 32'd0;
      e_lo = 32'd42;
`else
      e_hi = 32'd1;
      e_lo = 32'h7FFFFFFF;
`endif

      for (int t = 0; t < 40; t++) begin
         rdiv = $urandom_range(0, 1) == 1;
         runs = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
         runs = $urandom_range(0, 1) == 1;
`endif
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = $urandom_range(0, 15);
            2: ra = 32'h80000000;
            3: rb = 32'hFFFFFFFF;
            default: ;
         endcase
         model(rdiv, runs, ra, rb, e_hi, e_lo, e_dz);
         run_op(rdiv, ra, rb, runs, lat);
         check($sformatf("r%0d_lat", t), lat,
               e_dz ? 32'd2 : 32'd33);
         check($sformatf("r%0d_hi", t), hi_out, e_hi);
         check($sformatf("r%0d_lo", t), lo_out, e_lo);
         check($sformatf("r%0d_dz", t),
               {31'b0, div_zero}, {31'b0, e_dz});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
